regfile_param: RTL and testbench

// - Parametrised register file for the five-stage MIPS pipeline: two synchronous read

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 47 ++++
 rtl/regfile_param.sv | 87 ++++++++
 tb/tb_regfile_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the pipeline register file.
// Imported by the register file top and its read-port sub-module.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: selects zero / bypassed write data / array data,
// then captures it into the output register when rd_en is high.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int          DATA_W   = RF_DATA_W,
  parameter int          ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] next_data;

  // Priority: hardwired zero beats the bypass, which beats the stored value.
  always_comb begin
    // NOTE: default first so every path assigns next_data and no latch is inferred.
    next_data = mem_data;
    if (BYPASS != 0 && wr_en && wr_addr == addr) begin
      next_data = wr_data;
    end
    if (ZERO_REG != 0 && addr == ZERO_ADDR) begin
      next_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state to avoid ordering races.
    if (reset) begin
      data <= '0;
    end else if (rd_en) begin
      data <= next_data;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised pipeline register file: storage array, write port, debug read,
// and two registered read ports with optional zero register and write bypass.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int          DATA_W   = RF_DATA_W,
  parameter int          ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writeData,
  input  logic              RegWrite,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] dbgData
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = RegWrite && !(ZERO_REG != 0 && rd == ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is cleared on reset so no entry is ever read as X;
      // this is why it is built from flops rather than an inferred RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[rd] <= writeData;
    end
  end

  // Debug view shows the array as it stands; no forwarding of in-flight writes.
  always_comb begin
    dbgData = mem[dbgAddr];
    if (ZERO_REG != 0 && dbgAddr == ZERO_ADDR) begin
      dbgData = '0;
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port1 (
    .clk      (clk),
    .reset    (reset),
    .addr     (rs),
    .mem_data (mem[rs]),
    .wr_en    (RegWrite),
    .wr_addr  (rd),
    .wr_data  (writeData),
    .rd_en    (readEn),
    .data     (readData1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port2 (
    .clk      (clk),
    .reset    (reset),
    .addr     (rt),
    .mem_data (mem[rt]),
    .wr_en    (RegWrite),
    .wr_addr  (rd),
    .wr_data  (writeData),
    .rd_en    (readEn),
    .data     (readData2)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven in lockstep, checked
// against directed vectors and an array-based reference model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, rd, dbg_addr;
  logic [31:0] wd;
  logic        we, re;

  // Configs: 0 = zero reg + bypass, 1 = no zero reg + bypass, 2 = zero reg, no bypass
  logic [31:0] r1_0, r2_0, dbg_0, r1_1, r2_1, dbg_1, r1_2, r2_2, dbg_2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m  [3][32];
  logic [31:0] e1 [3];
  logic [31:0] e2 [3];
  bit          zr [3] = '{1'b1, 1'b0, 1'b1};
  bit          bp [3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  regfile_param #(.ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .writeData(wd),
    .RegWrite(we), .readEn(re), .dbgAddr(dbg_addr),
    .readData1(r1_0), .readData2(r2_0), .dbgData(dbg_0));

  regfile_param #(.ZERO_REG(0), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .writeData(wd),
    .RegWrite(we), .readEn(re), .dbgAddr(dbg_addr),
    .readData1(r1_1), .readData2(r2_1), .dbgData(dbg_1));

  regfile_param #(.ZERO_REG(1), .BYPASS(0)) dut2 (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .writeData(wd),
    .RegWrite(we), .readEn(re), .dbgAddr(dbg_addr),
    .readData1(r1_2), .readData2(r2_2), .dbgData(dbg_2));

  function automatic logic [31:0] get_r1(int c);
    return (c == 0) ? r1_0 : (c == 1) ? r1_1 : r1_2;
  endfunction

  function automatic logic [31:0] get_r2(int c);
    return (c == 0) ? r2_0 : (c == 1) ? r2_1 : r2_2;
  endfunction

  function automatic logic [31:0] get_dbg(int c);
    return (c == 0) ? dbg_0 : (c == 1) ? dbg_1 : dbg_2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Value a read port of config c should capture for address a at this edge.
  function automatic logic [31:0] ref_read(int c, logic [4:0] a);
    if (zr[c] && a == 5'd0) return 32'h0;
    if (bp[c] && we && rd == a) return wd;
    return m[c][a];
  endfunction

  // Advance the model across one edge, clock the DUTs, compare every config.
  task automatic tick();
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) m[c][i] = 32'h0;
        e1[c] = 32'h0;
        e2[c] = 32'h0;
      end else begin
        if (re) begin
          e1[c] = ref_read(c, rs);
          e2[c] = ref_read(c, rt);
        end
        if (we && !(zr[c] && rd == 5'd0)) m[c][rd] = wd;
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("model rd1 cfg%0d", c), get_r1(c), e1[c]);
      check($sformatf("model rd2 cfg%0d", c), get_r2(c), e2[c]);
      check($sformatf("model dbg cfg%0d a=%0d", c, dbg_addr), get_dbg(c),
            (zr[c] && dbg_addr == 5'd0) ? 32'h0 : m[c][dbg_addr]);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic [4:0] a_rd,
                       input logic [31:0] d, input logic r, input logic [4:0] a_rs,
                       input logic [4:0] a_rt);
    reset = rst; we = w; rd = a_rd; wd = d; re = r; rs = a_rs; rt = a_rt;
  endtask

  typedef struct {
    logic        rst;
    logic        w;
    logic [4:0]  a_rd;
    logic [31:0] d;
    logic        r;
    logic [4:0]  a_rs;
    logic [4:0]  a_rt;
    logic [31:0] x1;
    logic [31:0] x2;
  } vec_t;

  vec_t vecs [10];

  initial begin
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 32; i++) m[c][i] = 32'h0;
    for (int c = 0; c < 3; c++) begin e1[c] = 32'h0; e2[c] = 32'h0; end
    dbg_addr = 5'd0;

    // Expectations are for config 0 (zero reg + bypass)
    vecs[0] = '{1'b0, 1'b1, 5'd1, 32'h0000000A, 1'b1, 5'd0, 5'd0, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, 5'd2, 32'h0000000B, 1'b1, 5'd1, 5'd1, 32'hA,        32'hA};
    vecs[2] = '{1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd1, 5'd2, 32'hA,        32'hB};
    vecs[3] = '{1'b0, 1'b1, 5'd8, 32'h00000009, 1'b1, 5'd7, 5'd7, 32'h12345678, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd8, 32'h12345678, 32'h9};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 5'd2, 32'hA,        32'hB};
    vecs[6] = '{1'b0, 1'b1, 5'd1, 32'h0000000C, 1'b0, 5'd2, 5'd1, 32'hA,        32'hB};
    vecs[7] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 5'd1, 32'hB,        32'hC};
    vecs[8] = '{1'b1, 1'b1, 5'd4, 32'h00000055, 1'b1, 5'd7, 5'd8, 32'h0,        32'h0};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd1, 32'h0,        32'h0};

    // Reset state, then reset-clear of a written entry
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    check("reset rd1", r1_0, 32'h0);
    check("reset rd2", r2_0, 32'h0);
    drive(0, 1, 5, 32'hDEADBEEF, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 1, 5, 5);
    tick();
    check("rd1 during reset", r1_0, 32'h0);
    check("rd2 during reset", r2_0, 32'h0);
    drive(0, 0, 0, 0, 1, 5, 5);
    dbg_addr = 5'd5;
    tick();
    check("r5 after reset", r1_0, 32'h0);
    check("dbg r5 after reset", dbg_0, 32'h0);

    // Zero register: write to entry 0 with a same-cycle read of it
    drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
    dbg_addr = 5'd0;
    tick();
    check("zero same-cycle zr=1", r1_0, 32'h0);
    check("zero same-cycle zr=0", r1_1, 32'hFFFFFFFF);
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    check("zero read zr=1", r1_0, 32'h0);
    check("zero read zr=0", r1_1, 32'hFFFFFFFF);
    check("zero dbg zr=1", dbg_0, 32'h0);
    check("zero dbg zr=0", dbg_1, 32'hFFFFFFFF);

    // Bypass versus old value
    drive(0, 1, 3, 32'h11111111, 1, 0, 0);
    tick();
    drive(0, 1, 3, 32'h22222222, 1, 3, 3);
    tick();
    check("bypass on", r1_0, 32'h22222222);
    check("bypass off", r1_2, 32'h11111111);
    check("bypass off rd2", r2_2, 32'h11111111);
    drive(0, 0, 0, 0, 1, 3, 0);
    tick();
    check("after write bp=1", r1_0, 32'h22222222);
    check("after write bp=0", r1_2, 32'h22222222);

    // Directed table: dual read, stall hold, reset mid-write
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].w, vecs[i].a_rd, vecs[i].d, vecs[i].r,
            vecs[i].a_rs, vecs[i].a_rt);
      dbg_addr = 5'(i);
      tick();
      check($sformatf("vec%0d rd1", i), r1_0, vecs[i].x1);
      check($sformatf("vec%0d rd2", i), r2_0, vecs[i].x2);
    end

    // Random traffic, addresses biased low to provoke bypass and rs=rt hits
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31)), $urandom,
            ($urandom_range(0, 4) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) rt = rs;
      if ($urandom_range(0, 3) == 0) rs = rd;
      dbg_addr = 5'($urandom_range(0, 31));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
